argmax_stream: RTL and testbench

Streaming, parametrised argmax unit for the CNN classifier tail. It accepts one class score per cycle from the final fully-connected layer over a valid/ready handshake. It tracks the running maximum and its class index across a frame of `NUM_CLASSES` scores. It then presents the winning index and score on a valid/ready output port. It is the sequential, width- and class-count-generic successor to the fixed 10-input combinational result stage, and adds tie-breaking, signedness selection and back-pressure.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/score_cmp.sv | 24 ++
 rtl/argmax_stream.sv | 125 ++++++++++++
 tb/tb_argmax_stream.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN classifier tail.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cnn_pkg;

    // Default score width and class count of the final fully-connected layer.
    localparam int SCORE_W     = 46;
    localparam int NUM_CLASSES = 10;

    // Argmax frame state: gathering scores, or holding a result for downstream.
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } argmax_state_e;

endpackage

// File: rtl/score_cmp.sv
// Strict greater-than comparator for class scores, signed or unsigned.
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports: a, b - scores to compare; gt - 1 when a > b under the chosen signedness.
module score_cmp
    import cnn_pkg::*;
#(
    parameter int DATA_W = SCORE_W,
    parameter bit SIGNED = 1'b1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt
);

    always_comb begin
        if (SIGNED) begin
            gt = $signed(a) > $signed(b);
        end else begin
            gt = a > b;
        end
    end

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax over a frame of NUM_CLASSES scores, one score per cycle.
// Latency: out_valid rises on the edge that accepts the last score of a frame.
// Backpressure: in_ready drops for the whole HOLD phase until out_ready accepts the result.
// Ports: clk/rst (async active-high); in_valid/in_ready/in_score - score stream,
//        class index is arrival order; out_valid/out_ready/out_index/out_score -
//        frame winner; frame_cnt - results handed downstream, wraps at 16 bits.
module argmax_stream #(
    parameter int DATA_W      = cnn_pkg::SCORE_W,
    parameter int NUM_CLASSES = cnn_pkg::NUM_CLASSES,
    parameter int IDX_W       = $clog2(NUM_CLASSES),
    parameter bit SIGNED      = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_score,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_score,
    output logic [15:0]       frame_cnt
);

    import cnn_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    argmax_state_e     state_q,      state_d;
    logic [IDX_W-1:0]  cls_cnt_q,    cls_cnt_d;
    logic [DATA_W-1:0] best_score_q, best_score_d;
    logic [IDX_W-1:0]  best_idx_q,   best_idx_d;
    logic [IDX_W-1:0]  out_index_q,  out_index_d;
    logic [DATA_W-1:0] out_score_q,  out_score_d;
    logic [15:0]       frame_cnt_q,  frame_cnt_d;

    logic              in_gt_best;
    logic              in_xfer;
    logic              take_new;
    logic [DATA_W-1:0] win_score;
    logic [IDX_W-1:0]  win_idx;

    score_cmp #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_score_cmp (
        .a  (in_score),
        .b  (best_score_q),
        .gt (in_gt_best)
    );

    // Handshake outputs depend on registered state only, so no in->out comb path.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_index = out_index_q;
    assign out_score = out_score_q;
    assign frame_cnt = frame_cnt_q;

    assign in_xfer = in_valid && in_ready;

    // First score of a frame always wins; afterwards only a strictly larger one,
    // so ties keep the lower index. cls_cnt is 0 on the first score, which is
    // exactly the index to record then.
    assign take_new  = (cls_cnt_q == '0) || in_gt_best;
    assign win_score = take_new ? in_score  : best_score_q;
    assign win_idx   = take_new ? cls_cnt_q : best_idx_q;

    always_comb begin
        state_d      = state_q;
        cls_cnt_d    = cls_cnt_q;
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        out_index_d  = out_index_q;
        out_score_d  = out_score_q;
        frame_cnt_d  = frame_cnt_q;

        case (state_q)
            ACCUM: begin
                if (in_xfer) begin
                    best_score_d = win_score;
                    best_idx_d   = win_idx;
                    if (cls_cnt_q == LAST_IDX) begin
                        // Winner includes the score accepted on this edge.
                        out_score_d = win_score;
                        out_index_d = win_idx;
                        cls_cnt_d   = '0;
                        state_d     = HOLD;
                    end else begin
                        cls_cnt_d = cls_cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ACCUM;
            cls_cnt_q    <= '0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            out_index_q  <= '0;
            out_score_q  <= '0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cls_cnt_q    <= cls_cnt_d;
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
            out_index_q  <= out_index_d;
            out_score_q  <= out_score_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_argmax_stream.sv
// Directed self-checking bench for argmax_stream (signed, unsigned and small instances).
// Latency: checks sample on the falling edge, half a cycle after the active edge.
// Backpressure: exercised via out_ready holds and in_valid gaps.
module tb_argmax_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst;
    logic        in_valid;
    logic [45:0] in_score;
    logic        out_ready;

    logic        in_ready,   out_valid;
    logic [3:0]  out_index;
    logic [45:0] out_score;
    logic [15:0] frame_cnt;

    logic        u_in_ready, u_out_valid;
    logic [3:0]  u_out_index;
    logic [45:0] u_out_score;
    logic [15:0] u_frame_cnt;

    logic        s_valid, s_out_ready;
    logic [7:0]  s_score;
    logic        s_in_ready, s_out_valid;
    logic [1:0]  s_out_index;
    logic [7:0]  s_out_score;
    logic [15:0] s_frame_cnt;

    int n_pass  = 0;
    int n_total = 0;

    logic [45:0] fr [10];

    argmax_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_score  (in_score),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_score (out_score),
        .frame_cnt (frame_cnt)
    );

    argmax_stream #(.SIGNED(1'b0)) dut_u (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (u_in_ready),
        .in_score  (in_score),
        .out_valid (u_out_valid),
        .out_ready (out_ready),
        .out_index (u_out_index),
        .out_score (u_out_score),
        .frame_cnt (u_frame_cnt)
    );

    argmax_stream #(.DATA_W(8), .NUM_CLASSES(3)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_valid),
        .in_ready  (s_in_ready),
        .in_score  (s_score),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_index (s_out_index),
        .out_score (s_out_score),
        .frame_cnt (s_frame_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set10(input int a0, input int a1, input int a2, input int a3, input int a4,
                         input int a5, input int a6, input int a7, input int a8, input int a9);
        fr[0] = 46'(a0); fr[1] = 46'(a1); fr[2] = 46'(a2); fr[3] = 46'(a3); fr[4] = 46'(a4);
        fr[5] = 46'(a5); fr[6] = 46'(a6); fr[7] = 46'(a7); fr[8] = 46'(a8); fr[9] = 46'(a9);
    endtask

    // Streams fr[] with up to max_gap idle cycles before each score; returns at the
    // falling edge of the first HOLD cycle.
    task automatic stream(input int max_gap);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (max_gap > 0) begin
                int g;
                g = $urandom_range(max_gap, 0);
                repeat (g) begin
                    in_valid = 1'b0;
                    in_score = 46'($urandom);
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_score = fr[i];
            if (i == 9) check("no_early_valid", out_valid, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_score = '0;
    endtask

    initial begin
        int t1, t2;
        rst = 1'b1; in_valid = 1'b0; in_score = '0; out_ready = 1'b1;
        s_valid = 1'b0; s_score = '0; s_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_score", out_score, 0);
        check("rst_frame_cnt", frame_cnt, 0);

        // Basic frame, downstream always ready.
        set10(5, -3, 17, 2, 9, 0, -100, 16, 1, 4);
        stream(0);
        check("basic_valid", out_valid, 1);
        check("basic_index", out_index, 2);
        check("basic_score", out_score, 17);
        check("basic_in_ready", in_ready, 0);
        check("basic_cnt_before", frame_cnt, 0);
        @(negedge clk);
        check("basic_one_hold", out_valid, 0);
        check("basic_cnt", frame_cnt, 1);

        // All equal: lowest index wins.
        set10(-1, -1, -1, -1, -1, -1, -1, -1, -1, -1);
        stream(0);
        check("tie_all_index", out_index, 0);
        check("tie_all_score", out_score, 46'h3FFF_FFFF_FFFF);
        @(negedge clk);
        check("tie_all_cnt", frame_cnt, 2);

        // Duplicate maximum at 3 and 8.
        set10(1, 2, 3, 7, 0, -5, 6, 4, 7, 5);
        stream(0);
        check("tie_dup_index", out_index, 3);
        check("tie_dup_score", out_score, 7);
        @(negedge clk);

        // Max at last index, downstream stalled for 5 cycles with an in_valid pulse.
        out_ready = 1'b0;
        set10(0, 1, 2, 3, 4, 5, 6, 7, 8, 50);
        stream(0);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_index", out_index, 9);
            check("bp_score", out_score, 50);
            check("bp_cnt", frame_cnt, 3);
            in_valid = (k == 2);
            in_score = 46'd1000;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", out_valid, 0);
        check("bp_release_cnt", frame_cnt, 4);

        // Bubbles give the same answer as the gapless stream.
        set10(5, -3, 17, 2, 9, 0, -100, 16, 1, 4);
        stream(3);
        check("bubble_valid", out_valid, 1);
        check("bubble_index", out_index, 2);
        check("bubble_score", out_score, 17);
        @(negedge clk);
        check("bubble_cnt", frame_cnt, 5);

        // Back-to-back frames at full rate: NUM_CLASSES+1 cycles per frame.
        set10(5, -3, 17, 2, 9, 0, -100, 16, 1, 4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_score = fr[i];
        end
        @(negedge clk);
        t1 = cyc;
        check("b2b_a_valid", out_valid, 1);
        check("b2b_a_index", out_index, 2);
        check("b2b_a_in_ready", in_ready, 0);
        set10(0, 1, 2, 3, 4, 5, 6, 7, 8, 50);
        in_score = fr[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_score = fr[i];
        end
        @(negedge clk);
        t2 = cyc;
        in_valid = 1'b0;
        check("b2b_b_valid", out_valid, 1);
        check("b2b_b_index", out_index, 9);
        check("b2b_period", t2 - t1, 11);
        @(negedge clk);
        check("b2b_cnt", frame_cnt, 7);

        // Reset after 6 scores discards the partial frame.
        set10(1, 2, 3, 7, 0, -5, 6, 4, 7, 5);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_score = fr[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_index", out_index, 0);
        check("midrst_score", out_score, 0);
        check("midrst_cnt", frame_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        stream(0);
        check("midrst_fresh_index", out_index, 3);
        check("midrst_fresh_score", out_score, 7);
        @(negedge clk);
        check("midrst_fresh_cnt", frame_cnt, 1);

        // Reset during HOLD drops out_valid without waiting for a clock.
        out_ready = 1'b0;
        set10(5, -3, 17, 2, 9, 0, -100, 16, 1, 4);
        stream(0);
        check("holdrst_pre_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("holdrst_valid", out_valid, 0);
        check("holdrst_index", out_index, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        check("holdrst_in_ready", in_ready, 1);

        // Signedness: 2^45 is negative when signed, largest when unsigned.
        set10(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        fr[4] = 46'h2000_0000_0000;
        stream(0);
        check("signed_index", out_index, 0);
        check("signed_score", out_score, 1);
        check("unsigned_valid", u_out_valid, 1);
        check("unsigned_index", u_out_index, 4);
        check("unsigned_score", u_out_score, 46'h2000_0000_0000);
        @(negedge clk);

        // Small instance: 127,-128,127 keeps index 0; frame_cnt wraps.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_score = (i == 1) ? 8'h80 : 8'h7F;
        end
        @(negedge clk);
        s_valid = 1'b0;
        check("small_valid", s_out_valid, 1);
        check("small_in_ready", s_in_ready, 0);
        check("small_index", s_out_index, 0);
        check("small_score", s_out_score, 8'h7F);
        force dut_s.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        check("small_cnt_max", s_frame_cnt, 16'hFFFF);
        release dut_s.frame_cnt_q;
        s_out_ready = 1'b1;
        @(negedge clk);
        check("small_cnt_wrap", s_frame_cnt, 0);
        check("small_released", s_out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
